// File: rtl/prio_encoder_seq_pkg.sv
// Shared definitions for the sequential priority encoder: default line count,
// derived code width and the per-cycle action encoding of the output stage.
package prio_encoder_seq_pkg;

  localparam int ENC_N_DEFAULT = 4;

  // Width of the binary index for n request lines; a single line still needs one bit.
  function automatic int enc_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam logic [1:0] ACT_STALL = 2'd0;
  localparam logic [1:0] ACT_ISSUE = 2'd1;
  localparam logic [1:0] ACT_IDLE  = 2'd2;

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational lowest-index-wins priority encoder: isolates the lowest set
// bit of cand and reports its one-hot form, its binary index and whether any bit was set.
module prio_enc_comb
  import prio_encoder_seq_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  localparam int W = enc_w(N)
) (
  input  logic [N-1:0] cand,
  output logic [N-1:0] sel,
  output logic [W-1:0] idx,
  output logic         any
);

  // Two's-complement trick: cand & -cand keeps only the lowest set bit.
  assign sel = cand & (~cand + {{(N-1){1'b0}}, 1'b1});
  assign any = |cand;

  // Each index bit is the OR of the one-hot lines whose position has that bit set.
  for (genvar gi = 0; gi < W; gi++) begin : g_idx
    logic [N-1:0] mask;
    always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
        mask[i] = ((i >> gi) & 1) == 1;
      end
    end
    assign idx[gi] = |(sel & mask);
  end

endmodule

// File: rtl/prio_encoder_seq.sv
// Sequential priority encoder: captures request pulses into a pending set and
// issues one index per valid/ready handshake, lowest index first.
module prio_encoder_seq
  import prio_encoder_seq_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  localparam int W = enc_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  output logic [N-1:0] pending,
  output logic         dropped
);

  logic         take;
  logic         load;
  logic [N-1:0] cand;
  logic [N-1:0] sel;
  logic [W-1:0] idx;
  logic         any;
  logic [1:0]   act;

  assign take = out_valid & out_ready;
  assign load = ~out_valid | take;
  // New pulses join the pending set in the same cycle, so they can issue immediately.
  assign cand = pending | req_in;

  prio_enc_comb #(.N(N)) u_enc (
    .cand (cand),
    .sel  (sel),
    .idx  (idx),
    .any  (any)
  );

  always_comb begin
    act = ACT_STALL;
    if (load) begin
      act = any ? ACT_ISSUE : ACT_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      pending   <= '0;
      dropped   <= 1'b0;
    end else begin
      // A merge only counts against events already waiting, not ones being issued now.
      dropped <= |(req_in & pending);
      case (act)
        ACT_ISSUE: begin
          out_valid <= 1'b1;
          out_code  <= idx;
          pending   <= cand & ~sel;
        end
        ACT_IDLE: begin
          out_valid <= 1'b0;
          pending   <= '0;
        end
        default: begin
          pending <= cand;
        end
      endcase
    end
  end

endmodule
